// File: rtl/mprc_s2_miss_ctrl.sv
// Stage-2 dcache request register: retires hits in one cycle and hands misses to
// the MSHR file over valid/ready, nacking a miss that waits MAX_WAIT cycles.
module mprc_s2_miss_ctrl #(
  parameter int unsigned MAX_WAIT  = 8,
  parameter logic [15:0] LFSR_SEED = 16'h1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s1_valid,
  input  logic        s1_kill,
  output logic        s1_ready,
  input  logic [4:0]  s1_req_cmd,
  input  logic [31:0] s1_req_addr,
  input  logic [8:0]  s1_req_id,
  input  logic [3:0]  s1_tag_match_way,
  output logic [4:0]  s2_req_cmd,
  output logic [3:0]  s2_tag_match_way,
  output logic [3:0]  s2_replaced_way_en,
  input  logic        s2_hit,
  input  logic        s2_tag_match,
  input  logic [1:0]  s2_hit_state,
  input  logic [1:0]  s2_repl_meta_coh,
  input  logic [19:0] s2_repl_meta_tag,
  output logic        resp_valid,
  output logic [8:0]  resp_id,
  output logic        nack_valid,
  output logic        mshr_req_valid,
  input  logic        mshr_req_ready,
  output logic [4:0]  mshr_req_cmd,
  output logic [31:0] mshr_req_addr,
  output logic [8:0]  mshr_req_id,
  output logic [3:0]  mshr_req_way_en,
  output logic [1:0]  mshr_req_old_coh,
  output logic        mshr_req_wb,
  output logic [19:0] mshr_req_wb_tag,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] COH_EXCL_DIRTY = 2'd3;
  localparam logic [7:0] MAX_WAIT_C     = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EVAL      = 2'd1,
    MISS_WAIT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] s2_addr;
  logic [8:0]  s2_id;
  logic [7:0]  wait_cnt;
  logic [15:0] lfsr;

  // Hit-generator results frozen when the miss starts waiting, so the MSHR
  // request cannot change under a stalled handshake.
  logic        mw_tag_match;
  logic [1:0]  mw_hit_state;
  logic [1:0]  mw_repl_coh;
  logic [19:0] mw_repl_tag;

  logic        in_eval;
  logic        in_wait;
  logic        eval_hit;
  logic        mshr_fire;
  logic        done;
  logic        capture;
  logic        sel_tag_match;
  logic [1:0]  sel_hit_state;
  logic [1:0]  sel_repl_coh;
  logic [19:0] sel_repl_tag;
  logic [15:0] lfsr_next;

  // Handshake: a miss transfers to the MSHR file in any cycle where
  // mshr_req_valid && mshr_req_ready; valid is held with stable fields until then
  // or until the nack, and s1 transfers when s1_valid && !s1_kill && s1_ready.
  always_comb begin
    in_eval       = (state == EVAL);
    in_wait       = (state == MISS_WAIT);
    eval_hit      = in_eval && s2_hit;
    sel_tag_match = in_wait ? mw_tag_match : s2_tag_match;
    sel_hit_state = in_wait ? mw_hit_state : s2_hit_state;
    sel_repl_coh  = in_wait ? mw_repl_coh  : s2_repl_meta_coh;
    sel_repl_tag  = in_wait ? mw_repl_tag  : s2_repl_meta_tag;

    mshr_req_valid = (in_eval && !s2_hit) || in_wait;
    mshr_fire      = mshr_req_valid && mshr_req_ready;
    nack_valid     = in_wait && (wait_cnt == MAX_WAIT_C) && !mshr_req_ready;
    resp_valid     = eval_hit;
    resp_id        = (eval_hit || nack_valid) ? s2_id : 9'd0;
    done           = eval_hit || mshr_fire || nack_valid;

    s1_ready = reset_n && ((state == IDLE) || done);
    capture  = s1_valid && !s1_kill && s1_ready;

    mshr_req_cmd     = mshr_req_valid ? s2_req_cmd : 5'd0;
    mshr_req_addr    = mshr_req_valid ? s2_addr    : 32'd0;
    mshr_req_id      = mshr_req_valid ? s2_id      : 9'd0;
    mshr_req_way_en  = 4'd0;
    mshr_req_old_coh = 2'd0;
    mshr_req_wb      = 1'b0;
    mshr_req_wb_tag  = 20'd0;
    if (mshr_req_valid) begin
      mshr_req_way_en  = sel_tag_match ? s2_tag_match_way : s2_replaced_way_en;
      mshr_req_old_coh = sel_tag_match ? sel_hit_state : sel_repl_coh;
      mshr_req_wb      = !sel_tag_match && (sel_repl_coh == COH_EXCL_DIRTY);
      mshr_req_wb_tag  = sel_repl_tag;
    end

    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      s2_req_cmd         <= 5'd0;
      s2_tag_match_way   <= 4'd0;
      s2_replaced_way_en <= 4'd0;
      s2_addr            <= 32'd0;
      s2_id              <= 9'd0;
      wait_cnt           <= 8'd0;
      lfsr               <= LFSR_SEED;
      mw_tag_match       <= 1'b0;
      mw_hit_state       <= 2'd0;
      mw_repl_coh        <= 2'd0;
      mw_repl_tag        <= 20'd0;
    end else begin
      if (mshr_fire) begin
        lfsr <= lfsr_next;
      end
      // Victim way comes from the LFSR value before any step in this cycle.
      if (capture) begin
        s2_req_cmd         <= s1_req_cmd;
        s2_addr            <= s1_req_addr;
        s2_id              <= s1_req_id;
        s2_tag_match_way   <= s1_tag_match_way;
        s2_replaced_way_en <= 4'b0001 << lfsr[1:0];
      end
      if ((state == IDLE) || done) begin
        state    <= capture ? EVAL : IDLE;
        wait_cnt <= 8'd0;
      end else if (in_eval) begin
        state        <= MISS_WAIT;
        wait_cnt     <= 8'd1;
        mw_tag_match <= s2_tag_match;
        mw_hit_state <= s2_hit_state;
        mw_repl_coh  <= s2_repl_meta_coh;
        mw_repl_tag  <= s2_repl_meta_tag;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  a_no_resp_and_nack : assert property (@(posedge clk) disable iff (!reset_n)
    !(resp_valid && nack_valid));
  a_no_mshr_in_idle : assert property (@(posedge clk) disable iff (!reset_n)
    !((state == IDLE) && mshr_req_valid));
  a_miss_way_onehot : assert property (@(posedge clk) disable iff (!reset_n)
    mshr_req_valid |-> $onehot(mshr_req_way_en));
  a_mshr_stable : assert property (@(posedge clk) disable iff (!reset_n)
    (mshr_req_valid && !mshr_req_ready && !nack_valid) |=>
      (mshr_req_valid && $stable(mshr_req_addr) && $stable(mshr_req_id) &&
       $stable(mshr_req_cmd) && $stable(mshr_req_way_en) &&
       $stable(mshr_req_old_coh) && $stable(mshr_req_wb) &&
       $stable(mshr_req_wb_tag)));

endmodule

// File: tb/tb_mprc_s2_miss_ctrl.sv
// Directed bench for mprc_s2_miss_ctrl: inputs change on the falling edge and
// outputs are compared 2 ns later, away from the rising edge.
module tb_mprc_s2_miss_ctrl;

  localparam logic [4:0] M_XRD      = 5'b00000;
  localparam logic [4:0] M_XWR      = 5'b00001;
  localparam logic [1:0] COH_SHARED = 2'd1;
  localparam logic [1:0] COH_EXCL_C = 2'd2;
  localparam logic [1:0] COH_EXCL_D = 2'd3;

  logic        clk;
  logic        reset_n;
  logic        s1_valid;
  logic        s1_kill;
  logic        s1_ready;
  logic [4:0]  s1_req_cmd;
  logic [31:0] s1_req_addr;
  logic [8:0]  s1_req_id;
  logic [3:0]  s1_tag_match_way;
  logic [4:0]  s2_req_cmd;
  logic [3:0]  s2_tag_match_way;
  logic [3:0]  s2_replaced_way_en;
  logic        s2_hit;
  logic        s2_tag_match;
  logic [1:0]  s2_hit_state;
  logic [1:0]  s2_repl_meta_coh;
  logic [19:0] s2_repl_meta_tag;
  logic        resp_valid;
  logic [8:0]  resp_id;
  logic        nack_valid;
  logic        mshr_req_valid;
  logic        mshr_req_ready;
  logic [4:0]  mshr_req_cmd;
  logic [31:0] mshr_req_addr;
  logic [8:0]  mshr_req_id;
  logic [3:0]  mshr_req_way_en;
  logic [1:0]  mshr_req_old_coh;
  logic        mshr_req_wb;
  logic [19:0] mshr_req_wb_tag;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mprc_s2_miss_ctrl #(.MAX_WAIT(8), .LFSR_SEED(16'h1)) dut (
    .clk(clk), .reset_n(reset_n),
    .s1_valid(s1_valid), .s1_kill(s1_kill), .s1_ready(s1_ready),
    .s1_req_cmd(s1_req_cmd), .s1_req_addr(s1_req_addr), .s1_req_id(s1_req_id),
    .s1_tag_match_way(s1_tag_match_way),
    .s2_req_cmd(s2_req_cmd), .s2_tag_match_way(s2_tag_match_way),
    .s2_replaced_way_en(s2_replaced_way_en),
    .s2_hit(s2_hit), .s2_tag_match(s2_tag_match), .s2_hit_state(s2_hit_state),
    .s2_repl_meta_coh(s2_repl_meta_coh), .s2_repl_meta_tag(s2_repl_meta_tag),
    .resp_valid(resp_valid), .resp_id(resp_id), .nack_valid(nack_valid),
    .mshr_req_valid(mshr_req_valid), .mshr_req_ready(mshr_req_ready),
    .mshr_req_cmd(mshr_req_cmd), .mshr_req_addr(mshr_req_addr),
    .mshr_req_id(mshr_req_id), .mshr_req_way_en(mshr_req_way_en),
    .mshr_req_old_coh(mshr_req_old_coh), .mshr_req_wb(mshr_req_wb),
    .mshr_req_wb_tag(mshr_req_wb_tag), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    s1_valid = 0; s1_kill = 0; s1_req_cmd = 0; s1_req_addr = 0; s1_req_id = 0;
    s1_tag_match_way = 0; s2_hit = 0; s2_tag_match = 0; s2_hit_state = 0;
    s2_repl_meta_coh = 0; s2_repl_meta_tag = 0; mshr_req_ready = 0;
  endtask

  task automatic drive_s1(input logic [4:0] cmd, input logic [31:0] addr,
                          input logic [8:0] id, input logic [3:0] way);
    s1_valid = 1; s1_req_cmd = cmd; s1_req_addr = addr; s1_req_id = id;
    s1_tag_match_way = way;
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle_inputs();
    s1_valid = 1;
    @(negedge clk); #2;
    n_checks++;
    if ({s1_ready, resp_valid, nack_valid, mshr_req_valid, resp_id} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b resp=%b nack=%b mshr=%b id=%h, want all 0",
               s1_ready, resp_valid, nack_valid, mshr_req_valid, resp_id);
    end
    n_checks++;
    if ({s2_req_cmd, s2_tag_match_way, s2_replaced_way_en, dbg_state} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got cmd=%h match=%b repl=%b state=%0d, want all 0",
               s2_req_cmd, s2_tag_match_way, s2_replaced_way_en, dbg_state);
    end
    @(negedge clk);
    reset_n = 1;
    s1_valid = 0;
    #2;
    n_checks++;
    if (s1_ready !== 1'b1 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b state=%0d, want rdy=1 state=0", s1_ready, dbg_state);
    end
  endtask

  task automatic test_read_hit();
    @(negedge clk);
    drive_s1(M_XRD, 32'h1234_5040, 9'h005, 4'b0010);
    #2;
    n_checks++;
    if (s1_ready !== 1'b1) begin
      n_fail++; $display("FAIL hit_s1_ready: got %b want 1", s1_ready);
    end
    @(negedge clk);
    idle_inputs();
    s2_hit = 1; s2_tag_match = 1; s2_hit_state = COH_SHARED;
    #2;
    n_checks++;
    if ({resp_valid, resp_id, nack_valid, mshr_req_valid} !== {1'b1, 9'h005, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL hit_resp: got resp=%b id=%h nack=%b mshr=%b, want resp=1 id=005 nack=0 mshr=0",
               resp_valid, resp_id, nack_valid, mshr_req_valid);
    end
    n_checks++;
    if ({s2_req_cmd, s2_tag_match_way, s2_replaced_way_en, dbg_state} !==
        {M_XRD, 4'b0010, 4'b0010, 2'd1}) begin
      n_fail++;
      $display("FAIL hit_s2_regs: got cmd=%h match=%b repl=%b state=%0d, want cmd=00 match=0010 repl=0010 state=1",
               s2_req_cmd, s2_tag_match_way, s2_replaced_way_en, dbg_state);
    end
    @(negedge clk);
    idle_inputs();
    #2;
    n_checks++;
    if (resp_valid !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL hit_after: got resp=%b state=%0d, want resp=0 state=0", resp_valid, dbg_state);
    end
  endtask

  task automatic test_read_miss_dirty();
    @(negedge clk);
    drive_s1(M_XRD, 32'hCAFE_1F80, 9'h0A6, 4'b0000);
    @(negedge clk);
    idle_inputs();
    s2_repl_meta_coh = COH_EXCL_D; s2_repl_meta_tag = 20'hABCDE; mshr_req_ready = 1;
    #2;
    n_checks++;
    if ({mshr_req_valid, mshr_req_cmd, mshr_req_addr, mshr_req_id} !==
        {1'b1, M_XRD, 32'hCAFE_1F80, 9'h0A6}) begin
      n_fail++;
      $display("FAIL dirty_req: got v=%b cmd=%h addr=%h id=%h, want v=1 cmd=00 addr=cafe1f80 id=0a6",
               mshr_req_valid, mshr_req_cmd, mshr_req_addr, mshr_req_id);
    end
    n_checks++;
    if ({mshr_req_way_en, mshr_req_old_coh, mshr_req_wb, mshr_req_wb_tag} !==
        {4'b0010, COH_EXCL_D, 1'b1, 20'hABCDE}) begin
      n_fail++;
      $display("FAIL dirty_victim: got way=%b coh=%0d wb=%b tag=%h, want way=0010 coh=3 wb=1 tag=abcde",
               mshr_req_way_en, mshr_req_old_coh, mshr_req_wb, mshr_req_wb_tag);
    end
    n_checks++;
    if (resp_valid !== 1'b0 || s1_ready !== 1'b1) begin
      n_fail++; $display("FAIL dirty_flags: got resp=%b rdy=%b, want resp=0 rdy=1", resp_valid, s1_ready);
    end
    @(negedge clk);
    idle_inputs();
    #2;
    n_checks++;
    if (mshr_req_valid !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL dirty_after: got mshr=%b state=%0d, want 0 0", mshr_req_valid, dbg_state);
    end
  endtask

  // LFSR is 16'h0002 here: the victim is way 2, and a wrongly stepped LFSR
  // after the nack would pick way 0 for the next request.
  task automatic test_nack();
    @(negedge clk);
    drive_s1(M_XRD, 32'h0000_2A40, 9'h033, 4'b0000);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      idle_inputs();
      drive_s1(M_XWR, 32'h8000_0100, 9'h044, 4'b0100);
      s2_repl_meta_coh = COH_SHARED; s2_repl_meta_tag = 20'h12345;
      #2;
      n_checks++;
      if ({mshr_req_valid, mshr_req_addr, mshr_req_id, mshr_req_way_en, mshr_req_old_coh,
           mshr_req_wb, mshr_req_wb_tag} !==
          {1'b1, 32'h0000_2A40, 9'h033, 4'b0100, COH_SHARED, 1'b0, 20'h12345}) begin
        n_fail++;
        $display("FAIL nack_hold[%0d]: got v=%b addr=%h id=%h way=%b coh=%0d wb=%b tag=%h, want v=1 addr=00002a40 id=033 way=0100 coh=1 wb=0 tag=12345",
                 k, mshr_req_valid, mshr_req_addr, mshr_req_id, mshr_req_way_en,
                 mshr_req_old_coh, mshr_req_wb, mshr_req_wb_tag);
      end
      n_checks++;
      if (nack_valid !== (k == 8) || s1_ready !== (k == 8) || resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL nack_pulse[%0d]: got nack=%b rdy=%b resp=%b, want nack=%b rdy=%b resp=0",
                 k, nack_valid, s1_ready, resp_valid, k == 8, k == 8);
      end
      if (k == 8) begin
        n_checks++;
        if (resp_id !== 9'h033) begin
          n_fail++; $display("FAIL nack_id: got %h want 033", resp_id);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    s2_hit = 1; s2_tag_match = 1; s2_hit_state = COH_EXCL_C;
    #2;
    n_checks++;
    if ({resp_valid, resp_id, s2_req_cmd, s2_tag_match_way, s2_replaced_way_en} !==
        {1'b1, 9'h044, M_XWR, 4'b0100, 4'b0100}) begin
      n_fail++;
      $display("FAIL nack_next: got resp=%b id=%h cmd=%h match=%b repl=%b, want resp=1 id=044 cmd=01 match=0100 repl=0100",
               resp_valid, resp_id, s2_req_cmd, s2_tag_match_way, s2_replaced_way_en);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_write_excl_clean();
    @(negedge clk);
    drive_s1(M_XWR, 32'h0000_3080, 9'h011, 4'b0100);
    @(negedge clk);
    idle_inputs();
    s2_tag_match = 1; s2_hit_state = COH_EXCL_C;
    s2_repl_meta_coh = COH_EXCL_D; s2_repl_meta_tag = 20'h0F0F0; mshr_req_ready = 1;
    #2;
    n_checks++;
    if ({mshr_req_valid, mshr_req_cmd, mshr_req_id, mshr_req_way_en, mshr_req_old_coh,
         mshr_req_wb, mshr_req_wb_tag} !==
        {1'b1, M_XWR, 9'h011, 4'b0100, COH_EXCL_C, 1'b0, 20'h0F0F0}) begin
      n_fail++;
      $display("FAIL write_req: got v=%b cmd=%h id=%h way=%b coh=%0d wb=%b tag=%h, want v=1 cmd=01 id=011 way=0100 coh=2 wb=0 tag=0f0f0",
               mshr_req_valid, mshr_req_cmd, mshr_req_id, mshr_req_way_en,
               mshr_req_old_coh, mshr_req_wb, mshr_req_wb_tag);
    end
    n_checks++;
    if (s2_replaced_way_en !== 4'b0100) begin
      n_fail++; $display("FAIL write_repl: got %b want 0100", s2_replaced_way_en);
    end
    @(negedge clk);
    idle_inputs();
    #2;
    n_checks++;
    if (mshr_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL write_one_cycle: got mshr=%b want 0", mshr_req_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_v;
    exp_v = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i < 3) drive_s1(M_XRD, 32'h0000_0040 * (i + 1), 9'(i + 1), 4'b0001);
      s2_hit = (i > 0); s2_tag_match = (i > 0); s2_hit_state = COH_SHARED;
      #2;
      n_checks++;
      if (resp_valid !== exp_v[i] || (exp_v[i] && resp_id !== 9'(i))) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got resp=%b id=%h, want resp=%b id=%h", i, resp_valid, resp_id, exp_v[i], 9'(i));
      end
    end
    @(negedge clk);
    idle_inputs();
    #2;
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: got resp=%b want 0", resp_valid);
    end
  endtask

  // id 2 is killed, so the cycle after it sits in IDLE and must ignore s2_hit.
  task automatic test_kill();
    logic [4:0] exp_v;
    logic [8:0] exp_id [5];
    exp_v = 5'b01010;
    exp_id = '{9'h0, 9'h1, 9'h0, 9'h3, 9'h0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i < 3) drive_s1(M_XRD, 32'h0000_1000, 9'(i + 1), 4'b0001);
      s1_kill = (i == 1);
      s2_hit = (i > 0); s2_tag_match = (i > 0); s2_hit_state = COH_SHARED;
      #2;
      n_checks++;
      if (resp_valid !== exp_v[i] || (exp_v[i] && resp_id !== exp_id[i])) begin
        n_fail++;
        $display("FAIL kill[%0d]: got resp=%b id=%h, want resp=%b id=%h", i, resp_valid, resp_id, exp_v[i], exp_id[i]);
      end
    end
  endtask

  task automatic test_reset_mid_miss();
    @(negedge clk);
    idle_inputs();
    drive_s1(M_XRD, 32'h0000_4000, 9'h055, 4'b0000);
    @(negedge clk);
    idle_inputs();
    s2_repl_meta_coh = COH_SHARED; s2_repl_meta_tag = 20'h00777;
    #2;
    n_checks++;
    if (mshr_req_valid !== 1'b1 || mshr_req_way_en !== 4'b0001) begin
      n_fail++; $display("FAIL rst_miss_eval: got v=%b way=%b, want v=1 way=0001", mshr_req_valid, mshr_req_way_en);
    end
    @(negedge clk);
    #2;
    n_checks++;
    if (dbg_state !== 2'd2 || mshr_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_miss_wait: got state=%0d v=%b, want state=2 v=1", dbg_state, mshr_req_valid);
    end
    reset_n = 0;
    #1;
    n_checks++;
    if (mshr_req_valid !== 1'b0 || dbg_state !== 2'd0 || nack_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got v=%b state=%0d nack=%b, want 0 0 0", mshr_req_valid, dbg_state, nack_valid);
    end
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    idle_inputs();
    drive_s1(M_XRD, 32'h0000_5000, 9'h066, 4'b0001);
    @(negedge clk);
    idle_inputs();
    s2_hit = 1; s2_tag_match = 1; s2_hit_state = COH_SHARED;
    #2;
    n_checks++;
    if ({resp_valid, resp_id, s2_replaced_way_en} !== {1'b1, 9'h066, 4'b0010}) begin
      n_fail++;
      $display("FAIL rst_lfsr_seed: got resp=%b id=%h repl=%b, want resp=1 id=066 repl=0010",
               resp_valid, resp_id, s2_replaced_way_en);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_read_miss_dirty();
    test_nack();
    test_write_excl_clean();
    test_back_to_back();
    test_kill();
    test_reset_mid_miss();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
